// File: rtl/rx_iq_frame_sched_pkg.sv
// Shared types and sizing for the RX IQ frame scheduler and its sample ring buffer.
package rx_iq_frame_sched_pkg;

   localparam int unsigned DEPTH        = 8;
   localparam int unsigned BYTES_PER_CH = 8;
   localparam int unsigned PTR_W        = $clog2(DEPTH);
   localparam int unsigned LVL_W        = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   // Field order matches the byte order on the wire: rx1_q occupies the top 32 bits.
   typedef struct packed {
      logic [31:0] rx1_q;
      logic [31:0] rx1_i;
      logic [31:0] rx2_q;
      logic [31:0] rx2_i;
   } iq_entry_t;

endpackage

// File: rtl/iq_ring_buffer.sv
// 8-entry circular buffer of IQ sample sets; push while full is accepted only with a pop.
module iq_ring_buffer
   import rx_iq_frame_sched_pkg::*;
(
   input  logic             clk_in,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  iq_entry_t        wr_data,
   output iq_entry_t        rd_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   iq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr_q];
   assign level   = level_q;

   // Storage is deliberately not reset.
   always_ff @(posedge clk_in) begin
      if (!reset && do_push) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
      end
   end

endmodule

// File: rtl/rx_iq_frame_sched.sv
// Buffers DDC sample sets and serializes one set per rd_start as an 8- or 16-byte frame.
module rx_iq_frame_sched
   import rx_iq_frame_sched_pkg::*;
(
   input  logic        clk_in,
   input  logic        reset,
   input  logic        iq_valid,
   input  logic [31:0] rx1_i,
   input  logic [31:0] rx1_q,
   input  logic [31:0] rx2_i,
   input  logic [31:0] rx2_q,
   input  logic        rx2_en,
   input  logic        rd_start,
   input  logic        byte_strobe,
   input  logic        rd_abort,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        frame_busy,
   output logic        frame_done,
   output logic        underrun,
   output logic [3:0]  fill_level,
   output logic [7:0]  overflow_cnt
);

   state_e       state_q, state_d;
   logic [3:0]   idx_q, idx_d;
   logic         rx2_sel_q, rx2_sel_d;
   iq_entry_t    hold_q, hold_d;
   logic         underrun_q, underrun_d;
   logic [7:0]   ovf_q;
   iq_entry_t    wr_data, rd_data;
   logic         pop, full, empty, last_byte;
   logic [127:0] hold_bits, hold_shifted;

   assign wr_data = '{rx1_q: rx1_q, rx1_i: rx1_i, rx2_q: rx2_q, rx2_i: rx2_i};

   iq_ring_buffer u_ring (
      .clk_in  (clk_in),
      .reset   (reset),
      .push    (iq_valid),
      .pop     (pop),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .level   (fill_level)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rx2_sel_d  = rx2_sel_q;
      hold_d     = hold_q;
      underrun_d = 1'b0;
      pop        = 1'b0;
      last_byte  = (idx_q == (rx2_sel_q ? 4'(2 * BYTES_PER_CH - 1) : 4'(BYTES_PER_CH - 1)));
      unique case (state_q)
         StIdle: begin
            if (rd_start) begin
               pop        = !empty;
               hold_d     = empty ? '0 : rd_data;
               underrun_d = empty;
               rx2_sel_d  = rx2_en;
               idx_d      = '0;
               state_d    = StSend;
            end
         end
         StSend: begin
            if (rd_abort) begin
               state_d = StIdle;
            end else if (byte_strobe) begin
               if (last_byte) state_d = StDone;
               else           idx_d   = idx_q + 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         rx2_sel_q  <= 1'b0;
         hold_q     <= '0;
         underrun_q <= 1'b0;
         ovf_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rx2_sel_q  <= rx2_sel_d;
         hold_q     <= hold_d;
         underrun_q <= underrun_d;
         if (iq_valid && full && !pop && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
      end
   end

   // Current byte is always the top byte after shifting out the ones already sent.
   assign hold_bits    = hold_q;
   assign hold_shifted = hold_bits << {idx_q, 3'b000};

   assign byte_valid   = (state_q == StSend);
   assign byte_out     = byte_valid ? hold_shifted[127:120] : 8'h00;
   assign frame_busy   = (state_q != StIdle);
   assign frame_done   = (state_q == StDone);
   assign underrun     = underrun_q;
   assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_rx_iq_frame_sched.sv
// Self-checking bench: directed table, hand sequences and random traffic against a queue model.
module tb_rx_iq_frame_sched;

   logic        clk_in = 1'b0;
   logic        reset, iq_valid, rx2_en, rd_start, byte_strobe, rd_abort;
   logic [31:0] rx1_i, rx1_q, rx2_i, rx2_q;
   logic [7:0]  byte_out;
   logic        byte_valid, frame_busy, frame_done, underrun;
   logic [3:0]  fill_level;
   logic [7:0]  overflow_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_in = ~clk_in;

   rx_iq_frame_sched dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .iq_valid     (iq_valid),
      .rx1_i        (rx1_i),
      .rx1_q        (rx1_q),
      .rx2_i        (rx2_i),
      .rx2_q        (rx2_q),
      .rx2_en       (rx2_en),
      .rd_start     (rd_start),
      .byte_strobe  (byte_strobe),
      .rd_abort     (rd_abort),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .frame_busy   (frame_busy),
      .frame_done   (frame_done),
      .underrun     (underrun),
      .fill_level   (fill_level),
      .overflow_cnt (overflow_cnt)
   );

   // Reference model: a FIFO of sample sets plus the list of bytes still to send.
   logic [127:0] m_buf[$];
   logic [7:0]   m_bytes[$];
   bit           m_active, m_done, m_under;
   int           m_ovf;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      bit           idle, was_empty;
      logic [127:0] e;
      e = '0;
      if (reset) begin
         m_buf.delete();
         m_bytes.delete();
         m_active = 0;
         m_done   = 0;
         m_under  = 0;
         m_ovf    = 0;
         return;
      end
      idle      = !m_active && !m_done;
      was_empty = (m_buf.size() == 0);
      m_under   = 0;
      if (idle && rd_start) begin
         if (!was_empty) e = m_buf.pop_front();
         m_under = was_empty;
      end
      if (iq_valid) begin
         if (m_buf.size() < 8) m_buf.push_back({rx1_q, rx1_i, rx2_q, rx2_i});
         else if (m_ovf < 255) m_ovf++;
      end
      if (idle && rd_start) begin
         m_bytes.delete();
         for (int k = 0; k < (rx2_en ? 16 : 8); k++) m_bytes.push_back(e[127 - 8 * k -: 8]);
         m_active = 1;
      end else if (m_active) begin
         if (rd_abort) begin
            m_active = 0;
            m_bytes.delete();
         end else if (byte_strobe) begin
            void'(m_bytes.pop_front());
            if (m_bytes.size() == 0) begin
               m_active = 0;
               m_done   = 1;
            end
         end
      end else if (m_done) begin
         m_done = 0;
      end
   endtask

   task automatic model_check();
      logic [7:0] eb;
      eb = m_active ? m_bytes[0] : 8'h00;
      check("outputs_vs_model",
            {byte_out, byte_valid, frame_busy, frame_done, underrun, fill_level, overflow_cnt},
            {eb, m_active, m_active || m_done, m_done, m_under, 4'(m_buf.size()), 8'(m_ovf)});
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_in);
      #1;
      model_check();
   endtask

   task automatic clr();
      reset = 0; iq_valid = 0; rx2_en = 0; rd_start = 0; byte_strobe = 0; rd_abort = 0;
      rx1_i = 0; rx1_q = 0; rx2_i = 0; rx2_q = 0;
   endtask

   task automatic push(input logic [31:0] q1, i1, q2, i2);
      iq_valid = 1; rx1_q = q1; rx1_i = i1; rx2_q = q2; rx2_i = i2;
      tick();
      iq_valid = 0;
   endtask

   // Runs one complete frame; returns bytes with the first byte most significant.
   task automatic read_frame(input bit two, output logic [127:0] got);
      got = '0;
      rd_start = 1; rx2_en = two;
      tick();
      rd_start = 0; rx2_en = 0;
      for (int k = 0; k < (two ? 16 : 8); k++) begin
         got = {got[119:0], byte_out};
         byte_strobe = 1;
         tick();
      end
      byte_strobe = 0;
      check("frame_done_pulse", frame_done, 1);
      tick();
   endtask

   typedef struct {
      logic        rst, iqv, start, strobe;
      logic [31:0] q1, i1;
      logic        vld;
      logic [7:0]  byt;
      logic        done, busy, und;
      logic [3:0]  fill;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(logic rst, iqv, start, strobe, logic [31:0] q1, i1, logic vld,
                               logic [7:0] byt, logic done, busy, und, logic [3:0] fill);
      vec_t v;
      v.rst = rst; v.iqv = iqv; v.start = start; v.strobe = strobe; v.q1 = q1; v.i1 = i1;
      v.vld = vld; v.byt = byt; v.done = done; v.busy = busy; v.und = und; v.fill = fill;
      return v;
   endfunction

   logic [63:0]  seq;
   logic [127:0] got;
   logic [31:0]  sq, si;

   initial begin
      clr();
      // Single-channel frame followed by an underrun frame.
      seq = 64'h1122_3344_5566_7788;
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 32'h11223344, 32'h55667788, 0, 8'h00, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 8'h11, 0, 1, 0, 0));
      for (int k = 1; k < 8; k++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, seq[63 - 8 * k -: 8], 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 1, 1, 0));
      for (int k = 1; k < 8; k++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 8'h00, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));

      foreach (tbl[n]) begin
         reset = tbl[n].rst; iq_valid = tbl[n].iqv; rd_start = tbl[n].start;
         byte_strobe = tbl[n].strobe; rx1_q = tbl[n].q1; rx1_i = tbl[n].i1;
         tick();
         check($sformatf("table[%0d]", n),
               {byte_valid, byte_out, frame_done, frame_busy, underrun, fill_level, overflow_cnt},
               {tbl[n].vld, tbl[n].byt, tbl[n].done, tbl[n].busy, tbl[n].und, tbl[n].fill, 8'h00});
      end
      clr();

      // Dual-channel frame.
      reset = 1; tick(); reset = 0;
      push(32'h11223344, 32'h55667788, 32'hA1A2A3A4, 32'hB1B2B3B4);
      read_frame(1, got);
      check("dual_bytes", got, 128'h11223344_55667788_A1A2A3A4_B1B2B3B4);

      // Overflow: ten pushes, last two dropped, eight frames read back in order.
      reset = 1; tick(); reset = 0;
      for (int k = 1; k <= 10; k++) push((32'(k) << 24) | 32'(k), ~((32'(k) << 24) | 32'(k)), 0, 0);
      check("ovf_fill", fill_level, 8);
      check("ovf_cnt", overflow_cnt, 2);
      for (int k = 1; k <= 8; k++) begin
         sq = (32'(k) << 24) | 32'(k);
         si = ~sq;
         read_frame(0, got);
         check($sformatf("ovf_frame%0d", k), got, {64'h0, sq, si});
      end
      check("ovf_drained", fill_level, 0);

      // Push and pop together while full, then abort paths and mid-frame reset.
      reset = 1; tick(); reset = 0;
      for (int k = 0; k < 8; k++) push(32'(k), 32'(k), 0, 0);
      iq_valid = 1; rx1_q = 32'hCAFE0009; rd_start = 1;
      tick();
      iq_valid = 0; rd_start = 0;
      check("full_pushpop_fill", fill_level, 8);
      check("full_pushpop_ovf", overflow_cnt, 0);
      byte_strobe = 1; repeat (3) tick(); byte_strobe = 0;
      rd_abort = 1; tick(); rd_abort = 0;
      check("abort_idle", {byte_valid, frame_busy, frame_done}, 0);
      check("abort_fill", fill_level, 8);
      tick();
      check("abort_no_done", frame_done, 0);
      rd_start = 1; tick(); rd_start = 0;
      check("start_pops", fill_level, 7);
      byte_strobe = 1; repeat (3) tick();
      rd_abort = 1; tick(); rd_abort = 0; byte_strobe = 0;
      check("abort_wins", {byte_valid, frame_busy, frame_done, fill_level}, {3'b000, 4'd7});
      tick();
      check("abort_wins_no_done", frame_done, 0);
      rd_start = 1; tick(); rd_start = 0;
      byte_strobe = 1; repeat (2) tick(); byte_strobe = 0;
      reset = 1; iq_valid = 1; tick(); reset = 0; iq_valid = 0;
      check("reset_midframe",
            {byte_out, byte_valid, frame_busy, frame_done, underrun, fill_level, overflow_cnt}, 0);
      tick();
      check("reset_midframe_no_done", frame_done, 0);

      // Overflow counter saturation.
      repeat (270) push(32'h1, 32'h2, 32'h3, 32'h4);
      check("ovf_saturate", overflow_cnt, 255);

      // Random traffic: a filling phase then a draining phase.
      reset = 1; tick(); reset = 0;
      for (int c = 0; c < 4000; c++) begin
         reset       = ($urandom_range(0, 299) == 0);
         iq_valid    = (c < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
         rd_start    = ($urandom_range(0, 3) == 0);
         byte_strobe = ($urandom_range(0, 3) != 0);
         rd_abort    = ($urandom_range(0, 39) == 0);
         rx2_en      = $urandom_range(0, 1) == 1;
         rx1_q = $urandom; rx1_i = $urandom; rx2_q = $urandom; rx2_i = $urandom;
         tick();
      end
      clr();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_iq_frame_sched.md
RX_IQ_FRAME_SCHED -- requirements
Module: rx_iq_frame_sched

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all logic is clocked on the rising edge of clk_in.
REQ-002 clk_in  in  1  system clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 iq_valid  in  1  one-cycle DDC sample strobe, already synchronous to clk_in.
REQ-005 rx1_i, rx1_q, rx2_i, rx2_q  in  32 each  signed DDC samples, qualified by iq_valid.
REQ-006 rx2_en  in  1  include the RX2 pair in the frame.
REQ-007 rd_start  in  1  one-cycle request to begin a frame.
REQ-008 byte_strobe  in  1  consumer has taken byte_out; advance to the next byte.
REQ-009 rd_abort  in  1  abandon the current frame.
REQ-010 byte_out  out  8  current frame byte.
REQ-011 byte_valid  out  1  byte_out is meaningful.
REQ-012 frame_busy  out  1  state is not IDLE.
REQ-013 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-014 underrun  out  1  one-cycle pulse when a frame is served from an empty buffer.
REQ-015 fill_level  out  4  buffered entries, range 0..8.
REQ-016 overflow_cnt  out  8  count of dropped samples; saturates at 255.

Function
REQ-017 SHALL store each iq_valid sample set (all four words, 128 bits) in an 8-entry circular buffer; write and read pointers wrap 7->0.
REQ-018 SHALL discard a new sample when the buffer is full and no pop occurs in the same cycle, and increment overflow_cnt (saturating at 255).
REQ-019 SHALL accept both operations when a push and a pop occur in the same cycle, including when full; fill_level is then unchanged.
REQ-020 SHALL implement the FSM states IDLE, SEND and DONE; rd_start is honoured only in IDLE and ignored otherwise.
REQ-021 On rd_start at cycle T, SHALL do all of the following:
- pop the tail entry into hold registers, or load zeros and pulse underrun at T+1 if the buffer is empty;
- sample rx2_en;
- enter SEND at T+1 with byte index 0, byte_valid=1 and byte_out=byte 0.
REQ-022 SHALL emit bytes in this order, each word MSB first: rx1_q[31:24..7:0], rx1_i, then rx2_q and rx2_i if rx2_en was sampled as 1; the frame is 8 or 16 bytes.
REQ-023 Each byte_strobe in SEND SHALL advance the index, and byte_out SHALL update the next cycle.
REQ-024 A byte_strobe on the last byte SHALL cause the move to DONE with byte_valid=0; DONE pulses frame_done for one cycle and then returns to IDLE.
REQ-025 rd_abort in SEND SHALL return the FSM to IDLE next cycle with byte_valid=0 and no frame_done; the popped entry is lost.
REQ-026 If rd_abort and byte_strobe are asserted together, rd_abort SHALL take precedence.
REQ-027 byte_strobe outside SEND SHALL be ignored.
REQ-028 fill_level SHALL reflect pushes and pops one cycle after they occur.

Reset
REQ-029 Reset SHALL put the FSM in IDLE and clear both pointers, fill_level, overflow_cnt, byte_out, byte_valid, frame_busy, frame_done, underrun and the hold registers to 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without a frame_done pulse.
REQ-031 Reset SHALL take priority over iq_valid in the same cycle.
REQ-032 Buffer storage contents need not be cleared by reset.

Structure
REQ-033 A shared package SHALL hold DEPTH=8, BYTES_PER_CH=8, the FSM state enum and the 128-bit sample-entry type.
REQ-034 Storage and pointers SHALL live in one sub-module, iq_ring_buffer (push/pop/full/empty/level); rx_iq_frame_sched contains the FSM and the serializer.

Verification
REQ-035 Single-channel frame: push rx1_q=32'h11223344, rx1_i=32'h55667788, rx2_en=0; rd_start, then 8 strobes -> bytes 11,22,33,44,55,66,77,88; one frame_done; fill_level 1->0.
REQ-036 Dual-channel frame: rx2_en=1 with rx2_q=32'hA1A2A3A4, rx2_i=32'hB1B2B3B4 -> 16 bytes, the last 8 being A1..A4, B1..B4.
REQ-037 Underrun: rd_start on an empty buffer -> underrun pulse at T+1 and 8 bytes of 00.
REQ-038 Overflow: 10 pushes with no reads -> fill_level=8, overflow_cnt=2; the frames read back are samples 1..8 in order.
REQ-039 Simultaneous push and pop while full -> sample accepted, fill_level stays 8, overflow_cnt unchanged.
REQ-040 rd_abort after 3 strobes -> IDLE, no frame_done, fill_level decremented by 1; reset asserted mid-frame -> all outputs 0 on the next cycle.
